spi_frame_engine: RTL

- SPI target protocol engine, directly downstream of the 2-flop input synchronizers.
- Receives synchronized cs_n/sclk/mosi and CPOL/CPHA, oversampled by the system clock.
- Decodes 2-byte command/data frames into single-cycle register write/read strobes toward the config/status register bank, and shifts read data out on MISO.
- Constraint: sclk frequency must not exceed clk/8.

---
 rtl/spi_frame_engine_if.sv | 16 +
 rtl/spi_frame_engine.sv | 94 +++++++++
 2 files changed

// File: rtl/spi_frame_engine_if.sv
// spi_frame_engine_if: SPI pins plus register-bank strobes of the SPI frame engine.
interface spi_frame_engine_if #(parameter int ADDR_W = 4);
  logic [1:0] mode;
  logic spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic reg_we, reg_re;
  modport slave (
    input mode, spi_cs_n, spi_clk, spi_mosi, reg_rdata,
    output spi_miso, reg_addr, reg_wdata, reg_we, reg_re
  );
  modport master (
    output mode, spi_cs_n, spi_clk, spi_mosi, reg_rdata,
    input spi_miso, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/spi_frame_engine.sv
// spi_frame_engine: SPI target decoding 2-byte command/data frames into register strobes.
// Defining SPI_AUTOINC_EN enables burst mode with address auto-increment.
module spi_frame_engine #(
  parameter int ADDR_W = 4,
  parameter int REG_WIDTH = 8
) (
  input logic clk,
  input logic rstb,
  input logic ena,
  spi_frame_engine_if.slave bus
);
`ifdef SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic sclk_q, rw_q, smp_q, re_q, re_d1_q, we_q;
  logic rw_d, smp_d, re_d, we_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d, byte_v;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic rise, fall, smp_e, sft_e, sample, last, shift;
  // Sampling lands on the falling edge exactly when cpol and cpha differ.
  assign rise = ~bus.spi_cs_n & bus.spi_clk & ~sclk_q;
  assign fall = ~bus.spi_cs_n & ~bus.spi_clk & sclk_q;
  assign smp_e = (mode_q[1] ^ mode_q[0]) ? fall : rise;
  assign sft_e = (mode_q[1] ^ mode_q[0]) ? rise : fall;
  assign sample = smp_e & (state_q == CMD || state_q == DATA);
  assign last = sample & (cnt_q == 3'd7);
  assign byte_v = {rx_q[REG_WIDTH-2:0], bus.spi_mosi};
  assign shift = sft_e & smp_q & (state_q == DATA);
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state_q <= IDLE;
    else if (ena) state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (bus.spi_cs_n) state_d = IDLE;
    else if (state_q == IDLE) state_d = CMD;
    else if (last) state_d = (state_q == CMD || AUTOINC) ? DATA : DONE;
  end
  always_comb begin
    bus.spi_miso = (state_q == DATA) & ~rw_q & tx_q[REG_WIDTH-1];
    bus.reg_addr = addr_q;
    bus.reg_wdata = wdata_q;
    bus.reg_we = we_q;
    bus.reg_re = re_q;
  end
  always_comb begin
    mode_d = (state_q == IDLE && !bus.spi_cs_n) ? bus.mode : mode_q;
    cnt_d = bus.spi_cs_n ? 3'd0 : cnt_q + {2'b0, sample};
    rx_d = sample ? byte_v : rx_q;
    rw_d = (last && state_q == CMD) ? byte_v[REG_WIDTH-1] : rw_q;
    re_d = last && (state_q == CMD ? !byte_v[REG_WIDTH-1] : AUTOINC && !rw_q);
    we_d = last && state_q == DATA && rw_q;
    wdata_d = we_d ? byte_v : wdata_q;
    // Writes bump the address after their strobe; burst reads bump it together with the next strobe.
    addr_d = (last && state_q == CMD) ? byte_v[ADDR_W-1:0]
           : (AUTOINC && (we_q || (last && state_q == DATA && !rw_q))) ? addr_q + ADDR_W'(1) : addr_q;
    tx_d = re_d1_q ? bus.reg_rdata : shift ? {tx_q[REG_WIDTH-2:0], 1'b0} : tx_q;
    // The byte-closing sample never arms a shift, so a fresh byte holds its MSB.
    smp_d = (state_q != DATA || re_d1_q || shift) ? 1'b0 : sample ? !last : smp_q;
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      sclk_q <= 1'b0;
      mode_q <= '0;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      rw_q <= 1'b0;
      smp_q <= 1'b0;
      re_q <= 1'b0;
      re_d1_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= '0;
      addr_q <= '0;
    end else if (ena) begin
      sclk_q <= bus.spi_clk;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      rw_q <= rw_d;
      smp_q <= smp_d;
      re_q <= re_d;
      re_d1_q <= re_q;
      we_q <= we_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
    end
endmodule
